lpddr2_port_arbiter: RTL and testbench

//  Shares the single LPDDR2 user port (lpddr2_memory read_req/write_req/addr/inData/outData) between two

---
 rtl/lpddr2_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_lpddr2_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpddr2_port_arbiter.sv
// Round-robin arbiter sharing one LPDDR2 user port between fetch (p0) and load/store (p1).
// Ports: clk/rst, p0_*/p1_* requester sides, mem_* controller side, timeout_err, busy.
module lpddr2_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 4096,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_rreq,
  input  logic          p0_wreq,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_ack,
  input  logic          p1_rreq,
  input  logic          p1_wreq,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_ack,
  output logic          mem_rreq,
  output logic          mem_wreq,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  input  logic          mem_ready,
  output logic          timeout_err,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_q, grant_d;
  logic          op_write_q, op_write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic [15:0]   timer_q, timer_d;
  logic          err_q, err_d;

  logic req0, req1, pick0;
  logic [DW-1:0] ret_data;

  assign req0 = p0_rreq | p0_wreq;
  assign req1 = p1_rreq | p1_wreq;
  // p0 wins when alone, or when both ask and p1 was served last
  assign pick0 = req0 & (~req1 | last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    timer_d      = timer_q;
    err_d        = err_q;
    ret_data     = mem_rdata;
    unique case (state_q)
      IDLE: begin
        if (mem_ready && (req0 || req1)) begin
          grant_d    = ~pick0;
          // write takes priority when both strobes are held
          op_write_d = pick0 ? p0_wreq : p1_wreq;
          addr_d     = pick0 ? p0_addr : p1_addr;
          wdata_d    = pick0 ? p0_wdata : p1_wdata;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_done || timer_q == TMO_LAST) begin
          // a done on the timeout cycle still counts as success
          if (!mem_done) begin
            err_d    = 1'b1;
            ret_data = ERR_DATA;
          end
          if (!op_write_q) begin
            if (grant_q) p1_rdata_d = ret_data;
            else         p0_rdata_d = ret_data;
          end
          state_d = RESP;
        end else if (timer_q != 16'hFFFF) begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
    end
  end

  assign mem_rreq    = (state_q == ISSUE) & ~op_write_q;
  assign mem_wreq    = (state_q == ISSUE) & op_write_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign p0_ack      = (state_q == RESP) & ~grant_q;
  assign p1_ack      = (state_q == RESP) & grant_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign timeout_err = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Directed testbench for lpddr2_port_arbiter (TIMEOUT=8).
// Each task drives one scenario and checks outputs one time unit after the clock edge.
module tb_lpddr2_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_rreq, p0_wreq, p1_rreq, p1_wreq;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ack, p1_ack;
  logic        mem_rreq, mem_wreq;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done, mem_ready;
  logic        timeout_err, busy;

  int checks = 0;
  int failures = 0;

  lpddr2_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .p0_rreq(p0_rreq), .p0_wreq(p0_wreq), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_rreq(p1_rreq), .p1_wreq(p1_wreq), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .mem_rreq(mem_rreq), .mem_wreq(mem_wreq), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mem_ready(mem_ready), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p0_rreq = 0; p0_wreq = 0; p1_rreq = 0; p1_wreq = 0;
    p0_addr = 0; p0_wdata = 0; p1_addr = 0; p1_wdata = 0;
    mem_rdata = 0; mem_done = 0; mem_ready = 1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl busy=%b p0_ack=%b p1_ack=%b exp 0", busy, p0_ack, p1_ack);
    end
    checks++;
    if (mem_rreq !== 1'b0 || mem_wreq !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem rreq=%b wreq=%b err=%b exp 0", mem_rreq, mem_wreq, timeout_err);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h r0=%h r1=%h exp 0", mem_addr, mem_wdata, p0_rdata, p1_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    p0_addr = 32'h100; p0_rreq = 1'b1;
    tick();
    checks++;
    if (mem_rreq !== 1'b1 || mem_wreq !== 1'b0 || mem_addr !== 32'h100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rd_issue rreq=%b wreq=%b addr=%h busy=%b exp 1 0 100 1", mem_rreq, mem_wreq, mem_addr, busy);
    end
    tick();
    checks++;
    if (mem_rreq !== 1'b0 || p0_ack !== 1'b0) begin
      failures++;
      $display("FAIL rd_one_pulse rreq=%b ack=%b exp 0 0", mem_rreq, p0_ack);
    end
    tick(); tick(); tick();
    mem_done = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_done = 1'b0;
    checks++;
    if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL rd_ack p0_ack=%b p1_ack=%b rdata=%h exp 1 0 12345678", p0_ack, p1_ack, p0_rdata);
    end
    p0_rreq = 1'b0;
    tick();
    checks++;
    if (p0_ack !== 1'b0 || busy !== 1'b0 || p0_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL rd_after ack=%b busy=%b rdata=%h exp 0 0 12345678", p0_ack, busy, p0_rdata);
    end
  endtask

  task automatic test_both_after_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    p0_addr = 32'h200; p0_rreq = 1'b1;
    p1_addr = 32'h300; p1_wdata = 32'hCAFEF00D; p1_wreq = 1'b1;
    tick();
    checks++;
    if (mem_rreq !== 1'b1 || mem_addr !== 32'h200) begin
      failures++;
      $display("FAIL both_first rreq=%b addr=%h exp 1 200", mem_rreq, mem_addr);
    end
    tick();
    mem_done = 1'b1; mem_rdata = 32'h11112222;
    tick();
    mem_done = 1'b0;
    checks++;
    if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata !== 32'h11112222) begin
      failures++;
      $display("FAIL both_ack0 p0=%b p1=%b rdata=%h exp 1 0 11112222", p0_ack, p1_ack, p0_rdata);
    end
    p0_rreq = 1'b0;
    tick(); tick();
    checks++;
    if (mem_wreq !== 1'b1 || mem_rreq !== 1'b0 || mem_addr !== 32'h300 || mem_wdata !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL both_wr wreq=%b rreq=%b addr=%h wdata=%h exp 1 0 300 cafef00d", mem_wreq, mem_rreq, mem_addr, mem_wdata);
    end
    tick();
    mem_done = 1'b1; mem_rdata = 32'h55555555;
    tick();
    mem_done = 1'b0;
    checks++;
    if (p1_ack !== 1'b1 || p0_ack !== 1'b0 || p1_rdata !== 32'h0) begin
      failures++;
      $display("FAIL both_ack1 p1=%b p0=%b r1=%h exp 1 0 0", p1_ack, p0_ack, p1_rdata);
    end
    p1_wreq = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    bit seen;
    p0_addr = 32'h400; p0_rreq = 1'b1;
    p1_addr = 32'h500; p1_wdata = 32'h0BADF00D; p1_wreq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        tick();
        seen = mem_rreq | mem_wreq;
      end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL rr_strobe txn=%0d got=none exp=strobe", i);
      end else if (mem_addr !== ((i % 2 == 0) ? 32'h400 : 32'h500)) begin
        failures++;
        $display("FAIL rr_grant txn=%0d addr=%h exp_port=%0d", i, mem_addr, i % 2);
      end
      tick();
      mem_done = 1'b1; mem_rdata = 32'hA0 + i;
      tick();
      mem_done = 1'b0;
      checks++;
      if (p0_ack !== (i % 2 == 0) || p1_ack !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL rr_ack txn=%0d p0=%b p1=%b exp_port=%0d", i, p0_ack, p1_ack, i % 2);
      end
    end
    checks++;
    if (p0_rdata !== 32'hA4) begin
      failures++;
      $display("FAIL rr_rdata got=%h exp=a4", p0_rdata);
    end
    p0_rreq = 1'b0; p1_wreq = 1'b0;
    tick();
  endtask

  task automatic test_min_latency();
    int cnt;
    bit s;
    cnt = 0; s = 1'b0;
    p0_addr = 32'h600; p0_rreq = 1'b1; mem_rdata = 32'h600D;
    for (int k = 0; k < 10; k++) begin
      tick();
      cnt++;
      if (p0_ack) break;
      mem_done = s;
      s = mem_rreq;
    end
    mem_done = 1'b0;
    checks++;
    if (cnt !== 3 || p0_ack !== 1'b1 || p0_rdata !== 32'h600D) begin
      failures++;
      $display("FAIL min_latency cycles=%0d ack=%b rdata=%h exp 3 1 600d", cnt, p0_ack, p0_rdata);
    end
    p0_rreq = 1'b0;
    tick();
  endtask

  task automatic test_done_at_timeout();
    p0_addr = 32'h680; p0_rreq = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) tick();
    mem_done = 1'b1; mem_rdata = 32'h77778888;
    tick();
    mem_done = 1'b0;
    checks++;
    if (p0_ack !== 1'b1 || p0_rdata !== 32'h77778888 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL done_at_tmo ack=%b rdata=%h err=%b exp 1 77778888 0", p0_ack, p0_rdata, timeout_err);
    end
    p0_rreq = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    p1_addr = 32'h700; p1_rreq = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      if (p1_ack) break;
    end
    checks++;
    if (n !== 9 || p1_ack !== 1'b1 || p1_rdata !== 32'hDEADBEEF || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout cycles=%0d ack=%b rdata=%h err=%b exp 9 1 deadbeef 1", n, p1_ack, p1_rdata, timeout_err);
    end
    p1_rreq = 1'b0;
    tick();
    p0_addr = 32'h710; p0_rreq = 1'b1;
    tick(); tick();
    mem_done = 1'b1; mem_rdata = 32'h13572468;
    tick();
    mem_done = 1'b0;
    checks++;
    if (p0_ack !== 1'b1 || p0_rdata !== 32'h13572468 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sticky ack=%b rdata=%h err=%b exp 1 13572468 1", p0_ack, p0_rdata, timeout_err);
    end
    p0_rreq = 1'b0;
    tick();
  endtask

  task automatic test_not_ready_and_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    mem_ready = 1'b0;
    p0_addr = 32'h800; p0_rreq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (mem_rreq !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL not_ready cyc=%0d rreq=%b busy=%b exp 0 0", k, mem_rreq, busy);
      end
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (mem_rreq !== 1'b1 || mem_addr !== 32'h800) begin
      failures++;
      $display("FAIL ready_issue rreq=%b addr=%h exp 1 800", mem_rreq, mem_addr);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; p0_rreq = 1'b0;
    checks++;
    if (busy !== 1'b0 || p0_ack !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait busy=%b ack=%b exp 0 0", busy, p0_ack);
    end
    mem_done = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_done = 1'b0;
    tick();
    checks++;
    if (p0_ack !== 1'b0 || busy !== 1'b0 || p0_rdata !== 32'h0 || mem_rreq !== 1'b0) begin
      failures++;
      $display("FAIL late_done ack=%b busy=%b rdata=%h rreq=%b exp 0 0 0 0", p0_ack, busy, p0_rdata, mem_rreq);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_both_after_reset();
    test_round_robin();
    test_min_latency();
    test_done_at_timeout();
    test_timeout();
    test_not_ready_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
